range_sum_ctrl: RTL and testbench
=================================

RANGE_SUM_CTRL -- requirements
Module: range_sum_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 64, operand and bound width.
REQ-002 SHALL have parameter ACC_W, default 64, engine count and accumulator width.
REQ-003 SHALL have parameter ENG_RST_CYC, default 3, number of cycles the engine is held in reset before each run.
REQ-004 SHALL have parameter WDOG_CYC, default 4096, the engine timeout in cycles.
REQ-005 SHALL have a single clock: clock  in  1  rising-edge clock for all state.
REQ-006 SHALL have reset: reset  in  1  synchronous, active-low.
REQ-007 SHALL have range_valid  in  1  range offered.
REQ-008 SHALL have range_ready  out  1  range accepted when valid&ready.
REQ-009 SHALL have range_lo  in  DATA_W  inclusive lower bound.
REQ-010 SHALL have range_hi  in  DATA_W  inclusive upper bound.
REQ-011 SHALL have range_last  in  1  final range of the batch.
REQ-012 SHALL have eng_reset  out  1  active-high reset to the count engine.
REQ-013 SHALL have eng_n  out  DATA_W  engine operand.
REQ-014 SHALL have eng_digs  out  DATA_W  decimal digit count of eng_n (0 gives 1).
REQ-015 SHALL have eng_count  in  ACC_W  engine result.
REQ-016 SHALL have eng_valid  in  1  engine result valid (may stay high).
REQ-017 SHALL have sum_out  out  ACC_W  batch total.
REQ-018 SHALL have sum_valid  out  1  one-cycle pulse, total final.
REQ-019 SHALL have err  out  1  sticky batch error flag.

Function
REQ-020 FSM states SHALL be IDLE, RST_HI, RUN_HI, RST_LO, RUN_LO, ACCUM, DONE.
REQ-021 range_ready SHALL be high only in IDLE; on accept, lo, hi and last are latched and the FSM enters RST_HI.
REQ-022 RST_HI SHALL drive eng_reset=1 with eng_n=hi for exactly ENG_RST_CYC cycles, then go to RUN_HI with eng_reset=0.
REQ-023 RUN_HI SHALL wait for an eng_valid rising edge (low the previous cycle) and latch eng_count as c_hi.
REQ-024 After RUN_HI, if lo==0 then c_lo=0 and the FSM SHALL go to ACCUM, skipping RST_LO/RUN_LO; otherwise it SHALL go to RST_LO with eng_n=lo-1.
REQ-025 RST_LO/RUN_LO SHALL mirror RST_HI/RUN_HI, latching c_lo.
REQ-026 ACCUM (1 cycle) SHALL add c_hi-c_lo (ACC_W modulo) to the accumulator.
REQ-027 After ACCUM, if last=1 the FSM SHALL go to DONE, otherwise to IDLE.
REQ-028 DONE SHALL pulse sum_valid for 1 cycle with sum_out = accumulator, then return to IDLE.
REQ-029 The first range accepted after DONE, or after reset, SHALL clear the accumulator and err in the same cycle.
REQ-030 If lo>hi, no engine run SHALL occur, the contribution SHALL be 0, err SHALL be set, and the FSM SHALL go directly to ACCUM.
REQ-031 eng_digs SHALL be registered with eng_n and SHALL equal the decimal digit count of eng_n, so 9 gives 1 and 10 gives 2.
REQ-032 eng_reset SHALL be 1 in IDLE, DONE and ACCUM.
REQ-033 sum_out SHALL hold its value between pulses.
REQ-034 An eng_valid edge seen outside RUN_* states SHALL be ignored.

Reset
REQ-035 While reset=0, the FSM SHALL be in IDLE with range_ready=0, eng_reset=1, eng_n=0, eng_digs=1, sum_out=0, sum_valid=0, err=0 and accumulator=0.
REQ-036 Reset asserted mid-operation SHALL abort the range; no partial sum is retained.
REQ-037 range_ready SHALL rise the first cycle after reset is released.

Configuration
REQ-038 With AOC_WDOG_EN defined, each RUN_* state SHALL count cycles; reaching WDOG_CYC without an eng_valid edge SHALL take the count as 0, set err and proceed as if valid.
REQ-039 With AOC_WDOG_EN undefined, RUN_* SHALL wait indefinitely and err SHALL be set only by the lo>hi rule in REQ-030.

Verification
Bench engine model: eng_count=2*eng_n, eng_valid rises 5 cycles after eng_reset falls and holds high.
REQ-040 Range [11,22] with last=1 -> c_hi=44, c_lo=20, one sum_valid pulse with sum_out=24, err=0.
REQ-041 Ranges [11,22], [95,115] (last) -> sum_out=24+42=66, and exactly two runs per range observed.
REQ-042 Range [0,7] last -> exactly one engine run, sum_out=14, and eng_digs=1 during the run.
REQ-043 Range [30,20] last -> no eng_reset deassertion, sum_out=0, err=1.
REQ-044 reset=0 asserted during RUN_LO of [11,22], then a new range [1,1] last -> sum_out=2 with no residue from the aborted range.
REQ-045 With AOC_WDOG_EN and WDOG_CYC=16, the model never asserts valid on [5,9] -> each run times out after 16 cycles, sum_out=0, err=1.

Source files
------------

// File: rtl/range_sum_ctrl.sv
// range_sum_ctrl: sequences an external digit-count engine over a batch of
// inclusive [lo, hi] ranges. Each range runs the engine at hi and at lo-1,
// and the difference goes into a batch accumulator. The total is published
// with a one-cycle sum_valid pulse after the range marked last.
// Optional build macro AOC_WDOG_EN: enables an engine watchdog that gives up
// on a run after WDOG_CYC cycles, counts it as 0 and flags err.
module range_sum_ctrl #(
    parameter int DATA_W      = 64,
    parameter int ACC_W       = 64,
    parameter int ENG_RST_CYC = 3,
    parameter int WDOG_CYC    = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              range_valid,
    output logic              range_ready,
    input  logic [DATA_W-1:0] range_lo,
    input  logic [DATA_W-1:0] range_hi,
    input  logic              range_last,
    output logic              eng_reset,
    output logic [DATA_W-1:0] eng_n,
    output logic [DATA_W-1:0] eng_digs,
    input  logic [ACC_W-1:0]  eng_count,
    input  logic              eng_valid,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid,
    output logic              err
);

    // One counter times both the engine reset hold and the watchdog.
    localparam int CNT_MAX = (ENG_RST_CYC > WDOG_CYC) ? ENG_RST_CYC : WDOG_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, RST_HI, RUN_HI, RST_LO, RUN_LO, ACCUM, DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DATA_W-1:0]  r_lo;
    logic               r_last;
    logic [ACC_W-1:0]   r_c_hi;
    logic [ACC_W-1:0]   r_c_lo;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_sum_out;
    logic               r_sum_valid;
    logic               r_err;
    logic               r_first;
    logic               r_vld_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_eng_n;
    logic [DATA_W-1:0]  r_eng_digs;

    logic               w_accept;
    logic               w_edge;
    logic               w_timeout;
    logic               w_run_done;
    logic               w_rst_done;
    logic [ACC_W-1:0]   w_run_cnt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_n_load;
    logic [DATA_W-1:0]  w_n_val;

    // Decimal digit count; zero counts as one digit. p never exceeds 10*n,
    // so four extra bits keep the running power of ten from overflowing.
    function automatic logic [DATA_W-1:0] dec_digits(input logic [DATA_W-1:0] n);
        logic [DATA_W+3:0] p;
        logic [DATA_W-1:0] d;
        d = DATA_W'(1);
        p = (DATA_W+4)'(10);
        for (int i = 0; i < DATA_W; i++) begin
            if ({4'b0000, n} >= p) begin
                d = d + DATA_W'(1);
                p = p * (DATA_W+4)'(10);
            end
        end
        return d;
    endfunction

    assign w_accept   = range_valid && reset && (r_state == IDLE);
    assign w_edge     = eng_valid && !r_vld_d;
    assign w_rst_done = (r_cnt == CNT_W'(ENG_RST_CYC - 1));
`ifdef AOC_WDOG_EN
    assign w_timeout  = ((r_state == RUN_HI) || (r_state == RUN_LO)) &&
                        (r_cnt == CNT_W'(WDOG_CYC - 1));
`else
    assign w_timeout  = 1'b0;
`endif
    assign w_run_done = w_edge || w_timeout;
    assign w_run_cnt  = w_edge ? eng_count : '0;
    assign w_acc_nxt  = r_acc + r_c_hi - r_c_lo;

    assign eng_n     = r_eng_n;
    assign eng_digs  = r_eng_digs;
    assign sum_out   = r_sum_out;
    assign sum_valid = r_sum_valid;
    assign err       = r_err;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state, engine operand selection and state-decoded outputs.
    always_comb begin
        w_next      = r_state;
        w_n_load    = 1'b0;
        w_n_val     = r_eng_n;
        range_ready = 1'b0;
        eng_reset   = 1'b1;
        case (r_state)
            IDLE: begin
                range_ready = reset;
                if (w_accept) begin
                    if (range_lo > range_hi) begin
                        w_next = ACCUM;
                    end else begin
                        w_next   = RST_HI;
                        w_n_load = 1'b1;
                        w_n_val  = range_hi;
                    end
                end
            end
            RST_HI: if (w_rst_done) w_next = RUN_HI;
            RUN_HI: begin
                eng_reset = 1'b0;
                if (w_run_done) begin
                    if (r_lo == '0) begin
                        w_next = ACCUM;
                    end else begin
                        w_next   = RST_LO;
                        w_n_load = 1'b1;
                        w_n_val  = r_lo - DATA_W'(1);
                    end
                end
            end
            RST_LO: if (w_rst_done) w_next = RUN_LO;
            RUN_LO: begin
                eng_reset = 1'b0;
                if (w_run_done) w_next = ACCUM;
            end
            ACCUM:   w_next = r_last ? DONE : IDLE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Engine operand and its digit count always change together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_eng_n    <= '0;
            r_eng_digs <= DATA_W'(1);
        end else if (w_n_load) begin
            r_eng_n    <= w_n_val;
            r_eng_digs <= dec_digits(w_n_val);
        end
    end

    // Range capture, run timing, result latching and batch accumulation.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_acc       <= '0;
            r_sum_out   <= '0;
            r_sum_valid <= 1'b0;
            r_err       <= 1'b0;
            r_first     <= 1'b1;
            r_vld_d     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_vld_d     <= eng_valid;
            r_sum_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_lo    <= range_lo;
                        r_last  <= range_last;
                        r_cnt   <= '0;
                        r_first <= 1'b0;
                        if (r_first) begin
                            r_acc <= '0;
                            r_err <= 1'b0;
                        end
                        if (range_lo > range_hi) begin
                            r_c_hi <= '0;
                            r_c_lo <= '0;
                            r_err  <= 1'b1;
                        end
                    end
                end
                RST_HI, RST_LO: begin
                    r_cnt <= w_rst_done ? '0 : r_cnt + CNT_W'(1);
                end
                RUN_HI: begin
`ifdef AOC_WDOG_EN
                    r_cnt <= r_cnt + CNT_W'(1);
`endif
                    if (w_run_done) begin
                        r_c_hi <= w_run_cnt;
                        r_cnt  <= '0;
                        if (r_lo == '0) r_c_lo <= '0;
                        if (!w_edge) r_err <= 1'b1;
                    end
                end
                RUN_LO: begin
`ifdef AOC_WDOG_EN
                    r_cnt <= r_cnt + CNT_W'(1);
`endif
                    if (w_run_done) begin
                        r_c_lo <= w_run_cnt;
                        r_cnt  <= '0;
                        if (!w_edge) r_err <= 1'b1;
                    end
                end
                ACCUM: begin
                    r_acc <= w_acc_nxt;
                    if (r_last) begin
                        r_sum_out   <= w_acc_nxt;
                        r_sum_valid <= 1'b1;
                        r_first     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_range_sum_ctrl.sv
// Directed bench for range_sum_ctrl. The engine model returns 2*eng_n and
// raises eng_valid 5 cycles after eng_reset falls, holding it until reset.
module tb_range_sum_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        range_valid;
    logic        range_ready;
    logic [63:0] range_lo;
    logic [63:0] range_hi;
    logic        range_last;
    logic        eng_reset;
    logic [63:0] eng_n;
    logic [63:0] eng_digs;
    logic [63:0] eng_count;
    logic        eng_valid;
    logic [63:0] sum_out;
    logic        sum_valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    range_sum_ctrl #(
        .DATA_W(64), .ACC_W(64), .ENG_RST_CYC(3), .WDOG_CYC(16)
    ) dut (
        .clock(clk), .reset(rst_n),
        .range_valid(range_valid), .range_ready(range_ready),
        .range_lo(range_lo), .range_hi(range_hi), .range_last(range_last),
        .eng_reset(eng_reset), .eng_n(eng_n), .eng_digs(eng_digs),
        .eng_count(eng_count), .eng_valid(eng_valid),
        .sum_out(sum_out), .sum_valid(sum_valid), .err(err)
    );

    // Engine model
    logic mute = 1'b0;
    int   m_cnt = 0;
    always @(posedge clk) begin
        if (eng_reset)      m_cnt <= 0;
        else if (m_cnt < 5) m_cnt <= m_cnt + 1;
    end
    assign eng_valid = !eng_reset && (m_cnt >= 5) && !mute;
    assign eng_count = eng_n << 1;

    // Observers: engine runs, digit count at run start, sum pulses
    logic        prev_er = 1'b1;
    int          runs = 0;
    int          pulses = 0;
    int          low_cyc = 0;
    logic [63:0] last_sum = '0;
    logic        last_err = 1'b0;
    logic [63:0] digs_log [0:63];
    always @(negedge clk) begin
        if (prev_er && !eng_reset) begin
            if (runs < 64) digs_log[runs] <= eng_digs;
            runs <= runs + 1;
        end
        prev_er <= eng_reset;
        if (!eng_reset) low_cyc <= low_cyc + 1;
        if (sum_valid) begin
            pulses   <= pulses + 1;
            last_sum <= sum_out;
            last_err <= err;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!range_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!range_ready) chk("ready_timeout", {63'd0, range_ready}, 64'd1);
    endtask

    task automatic send(input logic [63:0] lo, input logic [63:0] hi, input logic last);
        wait_ready();
        range_valid = 1'b1;
        range_lo    = lo;
        range_hi    = hi;
        range_last  = last;
        @(negedge clk);
        range_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int old);
        int n = 0;
        while (pulses == old && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (pulses == old) chk("pulse_timeout", 64'(pulses), 64'(old + 1));
    endtask

    task automatic wait_runs(input int target);
        int n = 0;
        while (runs < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (runs < target) chk("run_timeout", 64'(runs), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int p0;
        int r0;
        int l0;
        rst_n       = 1'b0;
        range_valid = 1'b0;
        range_lo    = '0;
        range_hi    = '0;
        range_last  = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        chk("rst_ready",     {63'd0, range_ready}, 64'd0);
        chk("rst_eng_reset", {63'd0, eng_reset},   64'd1);
        chk("rst_eng_n",     eng_n,                64'd0);
        chk("rst_eng_digs",  eng_digs,             64'd1);
        chk("rst_sum_out",   sum_out,              64'd0);
        chk("rst_sum_valid", {63'd0, sum_valid},   64'd0);
        chk("rst_err",       {63'd0, err},         64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, range_ready}, 64'd1);

        // [11,22] last: 44 - 20 = 24
        p0 = pulses; r0 = runs;
        send(64'd11, 64'd22, 1'b1);
        wait_pulse(p0);
        chk("a_sum",     last_sum, 64'd24);
        chk("a_err",     {63'd0, last_err}, 64'd0);
        chk("a_runs",    64'(runs - r0), 64'd2);
        chk("a_digs_hi", digs_log[r0], 64'd2);
        chk("a_digs_lo", digs_log[r0 + 1], 64'd2);
        chk("a_sv_low",  {63'd0, sum_valid}, 64'd0);
        repeat (3) @(negedge clk);
        chk("a_hold",    sum_out, 64'd24);
        chk("a_pulses",  64'(pulses - p0), 64'd1);

        // [11,22], [95,115] last: 24 + (230 - 188) = 66
        p0 = pulses; r0 = runs;
        send(64'd11, 64'd22, 1'b0);
        wait_runs(r0 + 2);
        wait_ready();
        chk("b_hold_mid",   sum_out, 64'd24);
        chk("b_no_pulse",   64'(pulses - p0), 64'd0);
        send(64'd95, 64'd115, 1'b1);
        wait_pulse(p0);
        chk("b_sum",     last_sum, 64'd66);
        chk("b_runs",    64'(runs - r0), 64'd4);
        chk("b_digs_115", digs_log[r0 + 2], 64'd3);
        chk("b_digs_94",  digs_log[r0 + 3], 64'd2);

        // [0,7] last: single run, 14
        p0 = pulses; r0 = runs;
        send(64'd0, 64'd7, 1'b1);
        wait_pulse(p0);
        chk("c_sum",  last_sum, 64'd14);
        chk("c_runs", 64'(runs - r0), 64'd1);
        chk("c_digs", digs_log[r0], 64'd1);

        // [30,20] last: inverted range, no run, err
        p0 = pulses; r0 = runs;
        send(64'd30, 64'd20, 1'b1);
        wait_pulse(p0);
        chk("d_sum",  last_sum, 64'd0);
        chk("d_err",  {63'd0, last_err}, 64'd1);
        chk("d_runs", 64'(runs - r0), 64'd0);

        // [10,10] last: digit boundary 10 -> 2, 9 -> 1; err cleared by new batch
        p0 = pulses; r0 = runs;
        send(64'd10, 64'd10, 1'b1);
        wait_pulse(p0);
        chk("e_sum",     last_sum, 64'd2);
        chk("e_err",     {63'd0, last_err}, 64'd0);
        chk("e_digs_10", digs_log[r0], 64'd2);
        chk("e_digs_9",  digs_log[r0 + 1], 64'd1);

        // Reset during RUN_LO of [11,22], then [1,1] last: 2
        p0 = pulses; r0 = runs;
        send(64'd11, 64'd22, 1'b1);
        wait_runs(r0 + 2);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("f_rst_ready",     {63'd0, range_ready}, 64'd0);
        chk("f_rst_eng_reset", {63'd0, eng_reset},   64'd1);
        chk("f_rst_sum_out",   sum_out,              64'd0);
        chk("f_rst_eng_n",     eng_n,                64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("f_ready", {63'd0, range_ready}, 64'd1);
        chk("f_no_pulse", 64'(pulses - p0), 64'd0);
        send(64'd1, 64'd1, 1'b1);
        wait_pulse(p0);
        chk("f_sum",    last_sum, 64'd2);
        chk("f_err",    {63'd0, last_err}, 64'd0);
        chk("f_pulses", 64'(pulses - p0), 64'd1);

`ifdef AOC_WDOG_EN
        // Silent engine on [5,9]: both runs time out after 16 cycles
        mute = 1'b1;
        p0 = pulses; r0 = runs; l0 = low_cyc;
        send(64'd5, 64'd9, 1'b1);
        wait_pulse(p0);
        chk("w_sum",     last_sum, 64'd0);
        chk("w_err",     {63'd0, last_err}, 64'd1);
        chk("w_runs",    64'(runs - r0), 64'd2);
        chk("w_run_cyc", 64'(low_cyc - l0), 64'd32);
        mute = 1'b0;
`else
        l0 = low_cyc;
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
